rom_dl_arbiter: RTL and testbench

//  Shares the single-port program ROM/RAM between the HPS ioctl download writer and the game CPU reader.

---
 rtl/rom_dl_pkg.sv | 14 +
 rtl/rom_dl_rdpipe.sv | 56 +++++
 rtl/rom_dl_arbiter.sv | 146 ++++++++++++++
 tb/tb_rom_dl_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types for the program-memory download arbiter: sequencing states, CPU read-pipe states
// and a helper for sizing counters.
package rom_dl_pkg;

  typedef enum logic [1:0] {EMPTY, LOAD, HOLD, RUN} st_e;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DONE} rd_st_e;

  // Width of a counter that must hold every value in 0..max_val.
  function automatic int cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/rom_dl_rdpipe.sv
// CPU read pipe: request accepted in cycle 0, memory data captured in cycle 1, rdy pulse in cycle 2.
// One read in flight; flush_i abandons an in-flight read with no completion pulse.
module rom_dl_rdpipe
  import rom_dl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              req_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              accept_o,
  output logic              rdy_o,
  output logic [DATA_W-1:0] data_o
);

  rd_st_e            rd_st_q, rd_st_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign accept_o = en_i && req_i && !flush_i && (rd_st_q == RD_IDLE);

  always_comb begin
    rd_st_d = rd_st_q;
    data_d  = data_q;
    unique case (rd_st_q)
      RD_IDLE: if (accept_o) rd_st_d = RD_WAIT;
      RD_WAIT: begin
        rd_st_d = RD_DONE;
        data_d  = rdata_i;
      end
      RD_DONE: rd_st_d = RD_IDLE;
      default: rd_st_d = RD_IDLE;
    endcase
    // A flushed read leaves the last delivered data on the bus.
    if (flush_i) begin
      rd_st_d = RD_IDLE;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_st_q <= RD_IDLE;
      data_q  <= '0;
    end else begin
      rd_st_q <= rd_st_d;
      data_q  <= data_d;
    end
  end

  assign rdy_o  = (rd_st_q == RD_DONE);
  assign data_o = data_q;

endmodule

// File: rtl/rom_dl_arbiter.sv
// Shares the program memory between the HPS download stream and the CPU read port, and holds the
// game in reset until a complete in-range image has loaded plus HOLD_CYC cycles.
module rom_dl_arbiter
  import rom_dl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ROM_SIZE = 8192,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic              Clk,
  input  logic              I_RESET_n,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [DATA_W-1:0] dn_data,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              game_reset,
  output logic              load_ok,
  output logic              load_err
);

  localparam int CNT_W  = cnt_w(ROM_SIZE);
  localparam int HOLD_W = cnt_w(HOLD_CYC - 1);

  st_e               st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              oob_q, oob_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic              grst_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic load_entry, in_range, wr_fire, wr_oob, hold_done, rd_en, rd_accept;

  assign load_entry = dn_download && (st_q != LOAD);
  assign in_range   = (32'(dn_addr) < ROM_SIZE);
  assign wr_fire    = dn_download && dn_wr && in_range;
  assign wr_oob     = dn_download && dn_wr && !in_range;
  assign hold_done  = (32'(hold_q) == HOLD_CYC - 1);
  // A download request in the same cycle as a CPU read wins; the read is never accepted.
  assign rd_en      = (st_q == RUN) && !dn_download;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    oob_d  = oob_q;
    ok_d   = ok_q;
    err_d  = err_q;
    unique case (st_q)
      EMPTY: if (dn_download) st_d = LOAD;
      LOAD: begin
        if (!dn_download) begin
          if ((32'(cnt_q) == ROM_SIZE) && !oob_q) begin
            st_d   = HOLD;
            ok_d   = 1'b1;
            hold_d = '0;
          end else begin
            st_d  = EMPTY;
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (dn_download)    st_d = LOAD;
        else if (hold_done) st_d = RUN;
        else                hold_d = hold_q + 1'b1;
      end
      RUN: if (dn_download) st_d = LOAD;
      default: st_d = EMPTY;
    endcase
    if (load_entry) begin
      cnt_d = '0;
      oob_d = 1'b0;
      ok_d  = 1'b0;
      err_d = 1'b0;
    end
    // Count is write strobes, so repeated addresses still advance it.
    if (wr_fire && (32'(cnt_d) < ROM_SIZE)) cnt_d = cnt_d + 1'b1;
    if (wr_oob) oob_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!I_RESET_n) begin
      st_q    <= EMPTY;
      cnt_q   <= '0;
      hold_q  <= '0;
      oob_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      grst_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      oob_q  <= oob_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      grst_q <= (st_d != RUN);
      we_q   <= wr_fire;
      if (wr_fire) begin
        addr_q  <= dn_addr;
        wdata_q <= dn_data;
      end else if (rd_accept) begin
        addr_q  <= cpu_addr;
      end
    end
  end

  rom_dl_rdpipe #(
    .DATA_W (DATA_W)
  ) u_rdpipe (
    .clk_i    (Clk),
    .rst_n_i  (I_RESET_n),
    .en_i     (rd_en),
    .flush_i  (load_entry),
    .req_i    (cpu_rd),
    .rdata_i  (mem_rdata),
    .accept_o (rd_accept),
    .rdy_o    (cpu_rdy),
    .data_o   (cpu_data)
  );

  // The read address goes straight to memory so data returns in time for the cycle-2 rdy.
  assign mem_addr   = rd_accept ? cpu_addr : addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign game_reset = grst_q;
  assign load_ok    = ok_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Bench for rom_dl_arbiter: table of download scenarios, hand sequences for read timing,
// reload and reset corners, and random reads checked against an image model.
`timescale 1ns/1ps
module tb_rom_dl_arbiter;
  import rom_dl_pkg::*;

  localparam int ROM  = 8192;
  localparam int HOLD = 16;

  logic        Clk = 1'b0;
  logic        I_RESET_n, dn_download, dn_wr, cpu_rd;
  logic [15:0] dn_addr, cpu_addr, mem_addr;
  logic [7:0]  dn_data, cpu_data, mem_wdata, mem_rdata;
  logic        cpu_rdy, mem_we, game_reset, load_ok, load_err;

  always #5 Clk = ~Clk;

  rom_dl_arbiter #(
    .ADDR_W(16), .DATA_W(8), .ROM_SIZE(ROM), .HOLD_CYC(HOLD)
  ) dut (
    .Clk(Clk), .I_RESET_n(I_RESET_n),
    .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .game_reset(game_reset), .load_ok(load_ok), .load_err(load_err)
  );

  // Single-port synchronous RAM, one cycle read latency.
  logic [7:0] ram [0:65535];
  always @(posedge Clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Expected memory image: last in-range byte the bench wrote to each address.
  logic [7:0] exp_mem [0:ROM-1];

  int we_total = 0, we_bad = 0, rdy_total = 0;
  always @(posedge Clk) begin
    #1;
    if (mem_we) begin
      we_total++;
      if ((32'(mem_addr) >= ROM) || !game_reset) we_bad++;
    end
    if (cpu_rdy) rdy_total++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic download(input int n_uniq, input int n_dup, input int oob_idx,
                          input logic [7:0] key);
    logic [15:0] a;
    logic [7:0]  d;
    dn_download = 1'b1;
    tick();
    for (int i = 0; i < n_uniq + n_dup; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        dn_wr = 1'b0;
        tick();
      end
      if (i < n_uniq) begin
        a = 16'(i);
        d = a[7:0] ^ key;
      end else begin
        a = 16'(i - n_uniq);
        d = ~(a[7:0] ^ key);
      end
      if (i == oob_idx) a = 16'h2000;
      dn_addr = a;
      dn_data = d;
      dn_wr   = 1'b1;
      if (32'(a) < ROM) exp_mem[a[12:0]] = d;
      tick();
    end
    dn_wr = 1'b0;
    tick();
    tick();
    dn_download = 1'b0;
  endtask

  task automatic cpu_read(input logic [12:0] a, output int lat, output logic [7:0] d);
    cpu_rd   = 1'b1;
    cpu_addr = {3'b000, a};
    lat      = -1;
    d        = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (cpu_rdy) begin
        lat = k;
        d   = cpu_data;
        break;
      end
    end
    cpu_rd = 1'b0;
    tick();
  endtask

  typedef struct {
    int         n_uniq;
    int         n_dup;
    int         oob_idx;
    logic [7:0] key;
    logic       exp_ok;
    logic       exp_err;
    int         exp_we;
    int         exp_hi;
  } dl_vec_t;

  dl_vec_t     vecs [6];
  int          w0, r0, hi, lat, idx, last, k, low_cnt;
  logic        ok_first;
  logic [7:0]  rd;
  logic [12:0] ra;
  logic [12:0] addrs [6];

  initial begin
    vecs[0] = '{8192, 0, -1,  8'h00, 1'b1, 1'b0, 8192, 16};
    vecs[1] = '{8000, 0, -1,  8'h11, 1'b0, 1'b1, 8000, 64};
    vecs[2] = '{8192, 0, 100, 8'h22, 1'b0, 1'b1, 8191, 64};
    vecs[3] = '{0,    0, -1,  8'h00, 1'b0, 1'b1, 0,    64};
    vecs[4] = '{8191, 1, -1,  8'h44, 1'b1, 1'b0, 8192, 16};
    vecs[5] = '{8192, 3, -1,  8'h00, 1'b1, 1'b0, 8195, 16};

    I_RESET_n = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    cpu_rd = 1'b0; cpu_addr = '0;
    tick();
    tick();
    chk("rst_game_reset", 32'(game_reset), 1);
    chk("rst_mem_we",     32'(mem_we),     0);
    chk("rst_cpu_rdy",    32'(cpu_rdy),    0);
    chk("rst_cpu_data",   32'(cpu_data),   0);
    chk("rst_mem_addr",   32'(mem_addr),   0);
    chk("rst_mem_wdata",  32'(mem_wdata),  0);
    chk("rst_load_ok",    32'(load_ok),    0);
    chk("rst_load_err",   32'(load_err),   0);
    chk("rst_state",      32'(dut.st_q),   32'(EMPTY));
    I_RESET_n = 1'b1;

    // No image yet: reads are ignored and the game stays in reset.
    w0 = we_total; r0 = rdy_total; low_cnt = 0;
    cpu_rd = 1'b1; cpu_addr = 16'h0005;
    repeat (100) begin
      tick();
      if (!game_reset) low_cnt++;
    end
    cpu_rd = 1'b0;
    chk("empty_grst_low_cycles", 32'(low_cnt), 0);
    chk("empty_rdy_count", 32'(rdy_total - r0), 0);
    chk("empty_we_count",  32'(we_total - w0), 0);

    for (int v = 0; v < 6; v++) begin
      w0 = we_total;
      download(vecs[v].n_uniq, vecs[v].n_dup, vecs[v].oob_idx, vecs[v].key);
      hi = 0; ok_first = 1'b0;
      for (int c = 0; c < 64; c++) begin
        tick();
        if (c == 0) ok_first = load_ok;
        if (game_reset) hi++;
        else break;
      end
      chk($sformatf("vec%0d_grst_high_cycles", v), 32'(hi), 32'(vecs[v].exp_hi));
      chk($sformatf("vec%0d_ok_in_hold", v), 32'(ok_first), 32'(vecs[v].exp_ok));
      chk($sformatf("vec%0d_load_ok", v),  32'(load_ok),  32'(vecs[v].exp_ok));
      chk($sformatf("vec%0d_load_err", v), 32'(load_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_we_count", v), 32'(we_total - w0), 32'(vecs[v].exp_we));
      chk($sformatf("vec%0d_state", v), 32'(dut.st_q),
          vecs[v].exp_ok ? 32'(RUN) : 32'(EMPTY));
    end
    chk("no_bad_writes", 32'(we_bad), 0);

    // Final image: data = addr[7:0], except addresses 0..2 overwritten with inverted data.
    cpu_read(13'h0005, lat, rd);
    chk("rd5_latency", 32'(lat), 2);
    chk("rd5_data", 32'(rd), 32'h05);
    cpu_read(13'h0001, lat, rd);
    chk("rd1_dup_data", 32'(rd), 32'hFE);

    // Continuous request: one completion every 3 cycles.
    for (int i = 0; i < 6; i++) addrs[i] = 13'($urandom_range(0, ROM - 1));
    cpu_rd = 1'b1; cpu_addr = {3'b000, addrs[0]};
    idx = 0; last = 0; k = 0;
    while (idx < 6 && k < 60) begin
      tick();
      k++;
      if (cpu_rdy) begin
        chk("b2b_data", 32'(cpu_data), 32'(exp_mem[addrs[idx]]));
        chk("b2b_spacing", 32'(k - last), (idx == 0) ? 32'd2 : 32'd3);
        last = k;
        idx++;
        if (idx < 6) cpu_addr = {3'b000, addrs[idx]};
      end
    end
    cpu_rd = 1'b0;
    chk("b2b_count", 32'(idx), 6);
    tick();

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      ra = 13'($urandom_range(0, ROM - 1));
      cpu_read(ra, lat, rd);
      chk("rand_latency", 32'(lat), 2);
      chk("rand_data", 32'(rd), 32'(exp_mem[ra]));
    end

    // Write strobes outside a download window never reach memory.
    w0 = we_total;
    dn_addr = 16'h0005; dn_data = 8'hEE; dn_wr = 1'b1;
    repeat (3) tick();
    dn_wr = 1'b0;
    tick();
    chk("stray_wr_we_count", 32'(we_total - w0), 0);
    cpu_read(13'h0005, lat, rd);
    chk("stray_wr_data", 32'(rd), 32'h05);

    // Download request in the same cycle as a read: the download wins.
    r0 = rdy_total;
    cpu_rd = 1'b1; cpu_addr = 16'h0007; dn_download = 1'b1;
    tick();
    chk("race_game_reset", 32'(game_reset), 1);
    chk("race_state", 32'(dut.st_q), 32'(LOAD));
    repeat (4) tick();
    cpu_rd = 1'b0;
    chk("race_rdy_count", 32'(rdy_total - r0), 0);

    // Reset in the middle of the load abandons it.
    for (int i = 0; i < 10; i++) begin
      dn_addr = 16'(i); dn_data = 8'(8'hA0 + i); dn_wr = 1'b1;
      exp_mem[13'(i)] = 8'(8'hA0 + i);
      tick();
    end
    dn_wr = 1'b0; I_RESET_n = 1'b0;
    tick();
    chk("midrst_state",      32'(dut.st_q),   32'(EMPTY));
    chk("midrst_load_ok",    32'(load_ok),    0);
    chk("midrst_load_err",   32'(load_err),   0);
    chk("midrst_game_reset", 32'(game_reset), 1);
    chk("midrst_mem_we",     32'(mem_we),     0);
    dn_download = 1'b0; I_RESET_n = 1'b1;
    repeat (5) tick();
    chk("midrst_stays_empty", 32'(dut.st_q), 32'(EMPTY));
    chk("midrst_grst_held",   32'(game_reset), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
